// File: rtl/icache_assoc_if.sv
// Fetch and memory-side signals of the set-associative instruction cache.
// The cache takes the slave view; the fetch unit / memory model takes the master view.
interface icache_assoc_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        hit;
  logic [31:0] hit_inst;
  logic        flush_in;
  logic        mem_ask;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_inst;

  modport slave (
    input  fetch_valid, fetch_pc, flush_in, mem_valid, mem_inst,
    output hit, hit_inst, mem_ask, mem_addr
  );

  modport master (
    output fetch_valid, fetch_pc, flush_in, mem_valid, mem_inst,
    input  hit, hit_inst, mem_ask, mem_addr
  );
endinterface

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with round-robin replacement, whole-line refill
// starting at word 0, and a flush that is deferred to the end of any refill in flight.
module icache_assoc #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  icache_assoc_if.slave bus
);

  localparam int unsigned LB    = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = (LB > 0) ? LB : 1;
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - 2 - LB - IDX_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  state_e r_state, w_state_d;

  logic [31:0]      r_data  [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0] r_tag   [WAYS][SETS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAY_W-1:0] r_rr    [SETS];

  logic             r_hit, r_mem_ask, r_flush_pend;
  logic [31:0]      r_hit_inst, r_mem_addr;
  logic [OFF_W-1:0] r_beat;
  logic [TAG_W-1:0] r_ref_tag;
  logic [IDX_W-1:0] r_ref_idx;
  logic [WAY_W-1:0] r_victim;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [31:0]      w_base, w_hit_word;
  logic             w_hit_any, w_start, w_beat_fire, w_last;
  logic [WAY_W-1:0] w_hit_way, w_victim_nxt;
  logic             w_hit_d, w_mem_ask_d;
  logic [31:0]      w_hit_inst_d, w_mem_addr_d;

  always_comb begin
    w_off  = (LB > 0) ? OFF_W'(bus.fetch_pc >> 2) : '0;
    w_idx  = IDX_W'(bus.fetch_pc >> (2 + LB));
    w_tag  = TAG_W'(bus.fetch_pc >> (2 + LB + IDX_W));
    w_base = 32'({w_tag, w_idx}) << (2 + LB);
  end

  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_hit_word   = r_data[w_hit_way][w_idx][w_off];
  assign w_start      = (r_state == StIdle) && bus.fetch_valid && !bus.flush_in && !w_hit_any;
  assign w_beat_fire  = (r_state == StRefill) && bus.mem_valid;
  assign w_last       = (r_beat == OFF_W'(LINE_WORDS - 1));
  assign w_victim_nxt = (r_victim == WAY_W'(WAYS - 1)) ? '0 : r_victim + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= StIdle;
    end else if (rdy_in) begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_start) w_state_d = StRefill;
      StRefill: if (w_beat_fire && w_last) w_state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs; flush suppresses the lookup entirely.
  always_comb begin
    w_hit_d      = 1'b0;
    w_hit_inst_d = r_hit_inst;
    w_mem_ask_d  = r_mem_ask;
    w_mem_addr_d = r_mem_addr;
    unique case (r_state)
      StIdle: begin
        if (bus.fetch_valid && !bus.flush_in && w_hit_any) begin
          w_hit_d      = 1'b1;
          w_hit_inst_d = w_hit_word;
        end
        if (w_start) begin
          w_mem_ask_d  = 1'b1;
          w_mem_addr_d = w_base;
        end
      end
      StRefill: begin
        if (w_beat_fire) begin
          w_mem_ask_d  = !w_last;
          w_mem_addr_d = w_last ? 32'd0 : r_mem_addr + 32'd4;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hit        <= 1'b0;
      r_hit_inst   <= '0;
      r_mem_ask    <= 1'b0;
      r_mem_addr   <= '0;
      r_beat       <= '0;
      r_ref_tag    <= '0;
      r_ref_idx    <= '0;
      r_victim     <= '0;
      r_flush_pend <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (rdy_in) begin
      r_hit      <= w_hit_d;
      r_hit_inst <= w_hit_inst_d;
      r_mem_ask  <= w_mem_ask_d;
      r_mem_addr <= w_mem_addr_d;
      if (w_start) begin
        r_ref_tag <= w_tag;
        r_ref_idx <= w_idx;
        r_victim  <= r_rr[w_idx];
        r_beat    <= '0;
      end
      if ((r_state == StIdle) && bus.flush_in) begin
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end
      if ((r_state == StRefill) && bus.flush_in) r_flush_pend <= 1'b1;
      if (w_beat_fire) begin
        r_beat <= r_beat + 1'b1;
        // Drop the victim on the first beat so a half-written line can never hit.
        if (r_beat == '0) r_valid[r_ref_idx][r_victim] <= 1'b0;
        if (w_last) begin
          r_rr[r_ref_idx] <= w_victim_nxt;
          r_flush_pend    <= 1'b0;
          if (r_flush_pend || bus.flush_in) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
          end else begin
            r_valid[r_ref_idx][r_victim] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && w_beat_fire) begin
      r_data[r_victim][r_ref_idx][r_beat] <= bus.mem_inst;
      if (w_last) r_tag[r_victim][r_ref_idx] <= r_ref_tag;
    end
  end

  assign bus.hit      = r_hit;
  assign bus.hit_inst = r_hit_inst;
  assign bus.mem_ask  = r_mem_ask;
  assign bus.mem_addr = r_mem_addr;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters: refill, hits, replacement,
// redirect, flush, freeze and asynchronous reset.
module tb_icache_assoc;
  logic clk;
  logic rst_n;
  logic rdy;
  int   n_chk;
  int   n_bad;

  icache_assoc_if bus ();

  icache_assoc u_dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.flush_in    = 1'b0;
    bus.mem_valid   = 1'b0;
    #1;
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_ask", 32'(bus.mem_ask), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_inst", bus.hit_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fetch pc, expecting a miss on the next edge.
  task automatic start_miss(input logic [31:0] pc);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    step();
    chk("miss_hit", 32'(bus.hit), 32'd0);
    chk("miss_ask", 32'(bus.mem_ask), 32'd1);
  endtask

  // Serve four beats, checking the requested address of each; optional idle gap and flush.
  task automatic refill(input logic [31:0] base, input bit gap, input int flush_at);
    for (int b = 0; b < 4; b++) begin
      if (gap) step();
      chk("rf_ask", 32'(bus.mem_ask), 32'd1);
      chk("rf_addr", bus.mem_addr, base + 32'(4 * b));
      chk("rf_hit", 32'(bus.hit), 32'd0);
      bus.mem_valid = 1'b1;
      bus.mem_inst  = word_of(base + 32'(4 * b));
      if (b == flush_at) bus.flush_in = 1'b1;
      step();
      bus.mem_valid = 1'b0;
      bus.flush_in  = 1'b0;
    end
    chk("rf_end_ask", 32'(bus.mem_ask), 32'd0);
    chk("rf_end_addr", bus.mem_addr, 32'd0);
    chk("rf_end_hit", 32'(bus.hit), 32'd0);
  endtask

  task automatic expect_hit(input logic [31:0] pc);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    step();
    chk("hit", 32'(bus.hit), 32'd1);
    chk("hit_inst", bus.hit_inst, word_of(pc));
    chk("hit_noask", 32'(bus.mem_ask), 32'd0);
  endtask

  task automatic expect_miss(input logic [31:0] pc);
    start_miss(pc);
    chk("miss_addr", bus.mem_addr, pc & 32'hFFFF_FFF0);
  endtask

  initial begin
    n_chk           = 0;
    n_bad           = 0;
    rst_n           = 1'b1;
    rdy             = 1'b1;
    bus.fetch_valid = 1'b0;
    bus.fetch_pc    = '0;
    bus.flush_in    = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_inst    = '0;
    #2;
    do_reset();

    // Cold miss and line fill, then hit two cycles after the last beat.
    start_miss(32'h100);
    refill(32'h100, 1'b0, -1);
    step();
    chk("t1_hit", 32'(bus.hit), 32'd1);
    chk("t1_inst", bus.hit_inst, word_of(32'h100));

    // Back-to-back hits within the line.
    expect_hit(32'h108);
    expect_hit(32'h10C);

    // Freeze holds the hit output even though pc now misses.
    rdy          = 1'b0;
    bus.fetch_pc = 32'h500;
    step();
    chk("frz_hit", 32'(bus.hit), 32'd1);
    chk("frz_inst", bus.hit_inst, word_of(32'h10C));
    chk("frz_ask", 32'(bus.mem_ask), 32'd0);
    rdy = 1'b1;
    step();
    chk("frz_miss_ask", 32'(bus.mem_ask), 32'd1);
    chk("frz_miss_addr", bus.mem_addr, 32'h500);
    refill(32'h500, 1'b1, -1);
    step();
    chk("t500_inst", bus.hit_inst, word_of(32'h500));

    // Set 0 holds 0x100 (way0) and 0x500 (way1); 0x900 evicts 0x100.
    expect_miss(32'h900);
    refill(32'h900, 1'b0, -1);
    expect_hit(32'h904);
    expect_hit(32'h504);
    expect_miss(32'h100);
    refill(32'h100, 1'b0, -1);
    expect_hit(32'h100);
    expect_hit(32'h908);
    expect_miss(32'h500);
    refill(32'h500, 1'b0, -1);
    expect_hit(32'h50C);

    // Redirect mid-refill: old line completes, new pc refills next.
    do_reset();
    start_miss(32'h100);
    bus.fetch_pc = 32'h200;
    refill(32'h100, 1'b0, -1);
    step();
    chk("redir_ask", 32'(bus.mem_ask), 32'd1);
    chk("redir_addr", bus.mem_addr, 32'h200);
    refill(32'h200, 1'b0, -1);
    step();
    chk("redir_hit", 32'(bus.hit), 32'd1);
    chk("redir_inst", bus.hit_inst, word_of(32'h200));
    expect_hit(32'h104);

    // Flush in idle wins over a hitting lookup.
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    chk("fl_idle_hit", 32'(bus.hit), 32'd0);
    chk("fl_idle_ask", 32'(bus.mem_ask), 32'd0);
    expect_miss(32'h100);

    // Flush during beat 1: every beat is still consumed, then the line misses again.
    refill(32'h100, 1'b0, 1);
    expect_miss(32'h100);
    refill(32'h100, 1'b0, -1);
    expect_hit(32'h10C);

    // Freeze mid-refill keeps the beat address.
    expect_miss(32'h600);
    rdy = 1'b0;
    step();
    step();
    chk("frz_rf_addr", bus.mem_addr, 32'h600);
    rdy = 1'b1;
    refill(32'h600, 1'b0, -1);
    expect_hit(32'h608);

    // Asynchronous reset mid-refill.
    expect_miss(32'h300);
    refill(32'h300, 1'b0, -1);
    expect_hit(32'h300);
    expect_miss(32'h700);
    bus.mem_valid = 1'b1;
    bus.mem_inst  = word_of(32'h700);
    step();
    bus.mem_valid = 1'b0;
    chk("pre_rst_addr", bus.mem_addr, 32'h704);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ask", 32'(bus.mem_ask), 32'd0);
    chk("arst_hit", 32'(bus.hit), 32'd0);
    chk("arst_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_miss(32'h300);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
